// File: rtl/present80_enc_serial_if.sv
// Host-side handshake bundle for the nibble-serial PRESENT-80 encryption core.
interface present80_enc_serial_if;
  logic        start;
  logic [63:0] plaintext;
  logic [79:0] key;
  logic        ready;
  logic        done;
  logic [63:0] ciphertext;

  modport master (
    output start, plaintext, key,
    input  ready, done, ciphertext
  );

  modport slave (
    input  start, plaintext, key,
    output ready, done, ciphertext
  );
endinterface

// File: rtl/present80_enc_serial.sv
// PRESENT-80 encryption, one S-box nibble per cycle; 31 rounds of
// ADDKEY + 16x SBOX + PLAYER, then FINAL whitening with K32 and a done pulse.
module present_sbox (
  input  logic [3:0] x_i,
  output logic [3:0] y_o
);
  always_comb begin
    y_o = 4'h0;
    unique case (x_i)
      4'h0: y_o = 4'hC;
      4'h1: y_o = 4'h5;
      4'h2: y_o = 4'h6;
      4'h3: y_o = 4'hB;
      4'h4: y_o = 4'h9;
      4'h5: y_o = 4'h0;
      4'h6: y_o = 4'hA;
      4'h7: y_o = 4'hD;
      4'h8: y_o = 4'h3;
      4'h9: y_o = 4'hE;
      4'hA: y_o = 4'hF;
      4'hB: y_o = 4'h8;
      4'hC: y_o = 4'h4;
      4'hD: y_o = 4'h7;
      4'hE: y_o = 4'h1;
      4'hF: y_o = 4'h2;
      default: y_o = 4'h0;
    endcase
  end
endmodule

module present80_enc_serial (
  input  logic                         clk,
  input  logic                         rst,
  present80_enc_serial_if.slave        bus
);
  typedef enum logic [2:0] {IDLE, ADDKEY, SBOX, PLAYER, FINAL} state_e;

  state_e      fsm_q, fsm_d;
  logic [63:0] state_q, state_d;
  logic [79:0] key_q, key_d;
  logic [4:0]  round_q, round_d;
  logic [3:0]  nib_q, nib_d;
  logic        done_q, done_d;
  logic [63:0] ct_q, ct_d;

  logic [3:0]  dp_sbox_in, dp_sbox_out;
  logic [3:0]  ks_sbox_in, ks_sbox_out;
  logic [79:0] key_rot, key_next;
  logic [63:0] perm;

  // Key schedule: rotate left 61, S-box the top nibble, fold in the round counter.
  assign key_rot    = {key_q[18:0], key_q[79:19]};
  assign ks_sbox_in = key_rot[79:76];
  assign key_next   = {ks_sbox_out, key_rot[75:20], key_rot[19:15] ^ round_q, key_rot[14:0]};

  assign dp_sbox_in = state_q[{nib_q, 2'b00} +: 4];

  present_sbox u_sbox_dp (.x_i(dp_sbox_in), .y_o(dp_sbox_out));
  present_sbox u_sbox_ks (.x_i(ks_sbox_in), .y_o(ks_sbox_out));

  for (genvar g = 0; g < 63; g++) begin : g_perm
    assign perm[(16 * g) % 63] = state_q[g];
  end
  assign perm[63] = state_q[63];

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    nib_d   = nib_q;
    done_d  = 1'b0;
    ct_d    = ct_q;
    unique case (fsm_q)
      IDLE: begin
        if (bus.start) begin
          state_d = bus.plaintext;
          key_d   = bus.key;
          round_d = 5'd1;
          nib_d   = '0;
          fsm_d   = ADDKEY;
        end
      end
      ADDKEY: begin
        state_d = state_q ^ key_q[79:16];
        key_d   = key_next;
        fsm_d   = SBOX;
      end
      SBOX: begin
        state_d[{nib_q, 2'b00} +: 4] = dp_sbox_out;
        nib_d = nib_q + 4'd1;
        if (nib_q == 4'd15) fsm_d = PLAYER;
      end
      PLAYER: begin
        state_d = perm;
        if (round_q == 5'd31) begin
          fsm_d = FINAL;
        end else begin
          round_d = round_q + 5'd1;
          fsm_d   = ADDKEY;
        end
      end
      FINAL: begin
        ct_d   = state_q ^ key_q[79:16];
        done_d = 1'b1;
        fsm_d  = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      key_q   <= '0;
      round_q <= '0;
      nib_q   <= '0;
      done_q  <= 1'b0;
      ct_q    <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      nib_q   <= nib_d;
      done_q  <= done_d;
      ct_q    <= ct_d;
    end
  end

  assign bus.ready      = (fsm_q == IDLE);
  assign bus.done       = done_q;
  assign bus.ciphertext = ct_q;
endmodule

// File: tb/tb_present80_enc_serial.sv
// Directed bench for present80_enc_serial against published PRESENT-80 vectors.
module tb_present80_enc_serial;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  present80_enc_serial_if bus();
  present80_enc_serial dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  int n;
  int extra;

  localparam logic [63:0] CT_ZERO  = 64'h5579C1387B228445;
  localparam logic [63:0] CT_KONES = 64'hE72C46C0F5945049;
  localparam logic [63:0] CT_PONES = 64'hA112FFC72F68417B;
  localparam logic [63:0] CT_BOTH  = 64'h3333DCD3213210D2;
  localparam logic [79:0] K_ONES   = {80{1'b1}};
  localparam logic [63:0] P_ONES   = {64{1'b1}};

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start is presented from a falling edge; inputs are scrambled right after capture.
  task automatic start_run(input logic [63:0] pt, input logic [79:0] k);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.plaintext = pt;
    bus.key       = k;
    @(posedge clk);
    #1;
    bus.start     = 1'b0;
    bus.plaintext = {$urandom, $urandom};
    bus.key       = {$urandom, $urandom, $urandom};
  endtask

  task automatic wait_done(input int budget, output int edges);
    edges = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
    end while (!bus.done && edges < budget);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.plaintext = '0;
    bus.key       = '0;

    #2 rst = 1'b1;
    #1;
    chk("rst_ready", bus.ready, 1);
    chk("rst_done", bus.done, 0);
    chk("rst_ct", bus.ciphertext, 0);
    @(negedge clk) rst = 1'b0;

    start_run('0, '0);
    chk("zero_busy_ready", bus.ready, 0);
    wait_done(1000, n);
    chk("zero_latency", n, 559);
    chk("zero_ct", bus.ciphertext, CT_ZERO);
    chk("zero_ready_at_done", bus.ready, 1);
    @(posedge clk); #1;
    chk("zero_done_pulse", bus.done, 0);

    start_run('0, K_ONES);
    wait_done(1000, n);
    chk("kones_latency", n, 559);
    chk("kones_ct", bus.ciphertext, CT_KONES);

    start_run(P_ONES, '0);
    wait_done(1000, n);
    chk("pones_ct", bus.ciphertext, CT_PONES);

    // Back-to-back: second start presented in the done cycle and held while busy.
    start_run('0, '0);
    wait_done(1000, n);
    chk("b2b_first_ct", bus.ciphertext, CT_ZERO);
    bus.start     = 1'b1;
    bus.plaintext = P_ONES;
    bus.key       = K_ONES;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (n == 300) begin
        chk("b2b_ct_hold", bus.ciphertext, CT_ZERO);
        chk("b2b_busy_ready", bus.ready, 0);
      end
    end while (!bus.done && n < 1000);
    chk("b2b_latency", n, 560);
    chk("b2b_ct", bus.ciphertext, CT_BOTH);
    bus.start = 1'b0;
    @(posedge clk); #1;
    chk("b2b_done_pulse", bus.done, 0);
    chk("b2b_idle_ready", bus.ready, 1);

    // Abort mid-run, then rerun the zero vector.
    start_run(P_ONES, K_ONES);
    repeat (299) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("abort_ct", bus.ciphertext, 0);
    chk("abort_ready", bus.ready, 1);
    chk("abort_done", bus.done, 0);
    @(negedge clk) rst = 1'b0;
    start_run('0, '0);
    wait_done(1000, n);
    chk("abort_rerun_latency", n, 559);
    chk("abort_rerun_ct", bus.ciphertext, CT_ZERO);
    extra = 0;
    repeat (600) begin
      @(posedge clk);
      #1;
      if (bus.done) extra++;
    end
    chk("abort_single_done", extra, 0);
    chk("abort_final_ct", bus.ciphertext, CT_ZERO);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/present80_enc_serial.md
# present80_enc_serial

Nibble-serial PRESENT-80 encryption core that consumes the team's 4-bit PRESENT S-box block. It holds a 64-bit cipher state and an 80-bit key register, and runs 31 rounds. Each round performs addRoundKey, then a 16-cycle S-box layer that pushes one nibble per cycle through a single S-box instance, then a one-cycle pLayer. A second S-box instance serves the key schedule. The block sits between the host register interface and the S-box leaf, and returns the ciphertext with a done pulse.

## Interface
- No parameters. Algorithm fixed to PRESENT-80, 31 rounds.
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only while ready=1
- plaintext  in  64  block to encrypt; bit 63 = MSB; sampled with start
- key  in  80  cipher key; bit 79 = MSB; sampled with start
- ready  out  1  core idle and able to accept start
- done  out  1  single-cycle pulse; ciphertext valid
- ciphertext  out  64  result register; holds until the next done

## Operation
- FSM states: IDLE, ADDKEY, SBOX, PLAYER, FINAL.
- IDLE, start=1:
  - state_reg <= plaintext; key_reg <= key; round <= 1 (5-bit); nib <= 0.
  - Next state ADDKEY.
- ADDKEY (1 cycle):
  - state_reg <= state_reg ^ key_reg[79:16].
  - key_reg <= update(key_reg, round).
  - Next state SBOX.
- update(k, r):
  - rot = {k[18:0], k[79:19]} (rotate left 61).
  - result = {S(rot[79:76]), rot[75:20], rot[19:15] ^ r, rot[14:0]}.
  - S is the dedicated key-schedule S-box instance.
- SBOX (16 cycles, nib = 0..15):
  - Nibble state_reg[4*nib+3 : 4*nib] is replaced by its S-box output. nib=0 is bits 3:0.
  - nib increments each cycle; after nib=15, nib wraps to 0 and the next state is PLAYER.
- PLAYER (1 cycle):
  - new[P(j)] = state_reg[j], with P(j) = 16*j mod 63 for j = 0..62, and P(63) = 63.
  - If round = 31: next state FINAL. Otherwise round <= round + 1 and next state ADDKEY.
- FINAL (1 cycle):
  - ciphertext <= state_reg ^ key_reg[79:16] (K32).
  - done <= 1 for exactly one cycle.
  - Next state IDLE.
- ready = (fsm == IDLE), decoded combinationally from the state register.
- start while ready=0 is ignored; it is not queued.
- Inputs are captured at start. Changes to plaintext or key mid-run have no effect.
- Internal state_reg and key_reg are not cleared at done. They are not observable.

## Timing
- Reset values (asynchronous, taking effect immediately):
  - fsm=IDLE, ready=1, done=0, ciphertext=0.
  - state_reg=0, key_reg=0, round=0, nib=0.
- Reset mid-run aborts the operation: no done, ciphertext=0, ready=1 once rst falls.
- Cycle budget, with start accepted at edge T:
  - Edges T+1..T+558 execute 31 rounds × 18 cycles (1 ADDKEY + 16 SBOX + 1 PLAYER).
  - Edge T+559 executes FINAL.
  - done=1 and ciphertext valid in the cycle after edge T+559. Latency is 559 cycles from the start edge to done.
- ready:
  - Falls in the cycle after the start edge.
  - Rises in the same cycle that done=1, since the FSM is back in IDLE.
- start=1 during the done cycle is accepted (back-to-back operation). The old ciphertext holds until the new done.
- Throughput: one block per 560 cycles when back-to-back.
- Both S-box instances are combinational. No pipeline stage exists outside the FSM registers.

## Test plan
- Reset to idle: assert rst mid-cycle, with no clock edge needed → ready=1, done=0, ciphertext=0.
- Zero vector: plaintext=0, key=0, start → done exactly 559 cycles after the start edge; ciphertext=64'h5579C1387B228445.
- Key all ones: plaintext=0, key=80'hFFFF_FFFFFFFF_FFFFFFFF → 64'hE72C46C0F5945049.
- Plaintext all ones: plaintext=64'hFFFFFFFFFFFFFFFF, key=0 → 64'hA112FFC72F68417B.
- Both all ones, back-to-back with the zero vector:
  - Second start issued in the first run's done cycle → 64'h3333DCD3213210D2 exactly 560 cycles after the first done.
  - Second start held every cycle while busy → no extra done pulses.
- Abort: assert rst at cycle 300 of a run, then start the zero vector again → a single done with 64'h5579C1387B228445, and no residue from the aborted run.
